puzzle_board: RTL and testbench

//  3x3 sliding-puzzle engine. Holds board state, applies player moves from raw

---
 rtl/puzzle_board.sv | 179 +++++++++++++++++
 tb/tb_puzzle_board.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_board.sv
// 3x3 sliding-puzzle engine: button synchronisers, board state, move/restart/win events.
// Optional feature: define LOCK_ON_WIN_EN to freeze the board against moves once solved.
module puzzle_board #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_d,
  input  logic        rst_n,
  input  logic        start_sw,
  input  logic [1:0]  board_sel,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_reset,
  output logic [35:0] board,
  output logic [3:0]  blank_pos,
  output logic        active,
  output logic        win_flag,
  output logic        reset_flag
);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    PLAY   = 2'd1,
    SOLVED = 2'd2
  } state_t;

`ifdef LOCK_ON_WIN_EN
  localparam bit LOCK_ON_WIN = 1'b1;
`else
  localparam bit LOCK_ON_WIN = 1'b0;
`endif

  // Cell 0 sits in the least significant nibble.
  localparam logic [35:0] SOLVED_BOARD = 36'h087654321;

  function automatic logic [35:0] preset_board(input logic [1:0] sel);
    case (sel)
      2'd0:    preset_board = 36'h807654321;
      2'd1:    preset_board = 36'h857604321;
      2'd2:    preset_board = 36'h687524310;
      default: preset_board = 36'h687524031;
    endcase
  endfunction

  function automatic logic [3:0] preset_blank(input logic [1:0] sel);
    case (sel)
      2'd0:    preset_blank = 4'd7;
      2'd1:    preset_blank = 4'd4;
      2'd2:    preset_blank = 4'd0;
      default: preset_blank = 4'd2;
    endcase
  endfunction

  // Button vector order: [0]=restart, [1]=up, [2]=down, [3]=left, [4]=right.
  logic [4:0] btn_raw;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_reset};

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0]  edge_q, edge_d;
  logic [4:0]  evt;
  state_t      state_q, state_d;
  logic [35:0] board_q, board_d;
  logic [3:0]  blank_q, blank_d;
  logic        active_q, active_d;
  logic        win_q, win_d;
  logic        reset_flag_q, reset_flag_d;

  logic        row0, row2, col0, col2;
  logic        move_ok;
  logic        moves_allowed;
  logic [3:0]  nbr;
  logic [35:0] swapped;

  always_comb begin
    sync_d[0] = btn_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    edge_d = sync_q[SYNC_STAGES-1];
    evt    = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Only the highest-priority direction is considered; an invalid one still masks the rest.
  always_comb begin
    row0    = (blank_q < 4'd3);
    row2    = (blank_q > 4'd5);
    col0    = (blank_q == 4'd0) || (blank_q == 4'd3) || (blank_q == 4'd6);
    col2    = (blank_q == 4'd2) || (blank_q == 4'd5) || (blank_q == 4'd8);
    move_ok = 1'b0;
    nbr     = blank_q;
    if (evt[1]) begin
      if (!row0) begin
        move_ok = 1'b1;
        nbr     = blank_q - 4'd3;
      end
    end else if (evt[2]) begin
      if (!row2) begin
        move_ok = 1'b1;
        nbr     = blank_q + 4'd3;
      end
    end else if (evt[3]) begin
      if (!col0) begin
        move_ok = 1'b1;
        nbr     = blank_q - 4'd1;
      end
    end else if (evt[4]) begin
      if (!col2) begin
        move_ok = 1'b1;
        nbr     = blank_q + 4'd1;
      end
    end
    swapped = board_q;
    swapped[{blank_q, 2'b00} +: 4] = board_q[{nbr, 2'b00} +: 4];
    swapped[{nbr, 2'b00} +: 4]     = 4'd0;
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    blank_d       = blank_q;
    active_d      = 1'b0;
    reset_flag_d  = 1'b0;
    win_d         = (board_q == SOLVED_BOARD);
    moves_allowed = (state_q == PLAY) || !LOCK_ON_WIN;
    case (state_q)
      SELECT: begin
        board_d = preset_board(board_sel);
        blank_d = preset_blank(board_sel);
        if (start_sw) state_d = PLAY;
      end
      PLAY, SOLVED: begin
        if (!start_sw) begin
          state_d = SELECT;
        end else if (evt[0]) begin
          board_d      = preset_board(board_sel);
          blank_d      = preset_blank(board_sel);
          reset_flag_d = 1'b1;
          state_d      = PLAY;
        end else if (moves_allowed && move_ok) begin
          board_d  = swapped;
          blank_d  = nbr;
          active_d = 1'b1;
          state_d  = (swapped == SOLVED_BOARD) ? SOLVED : PLAY;
        end
      end
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      edge_q       <= '0;
      state_q      <= SELECT;
      board_q      <= preset_board(2'd0);
      blank_q      <= preset_blank(2'd0);
      active_q     <= 1'b0;
      win_q        <= 1'b0;
      reset_flag_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      board_q      <= board_d;
      blank_q      <= blank_d;
      active_q     <= active_d;
      win_q        <= win_d;
      reset_flag_q <= reset_flag_d;
    end
  end

  assign board      = board_q;
  assign blank_pos  = blank_q;
  assign active     = active_q;
  assign win_flag   = win_q;
  assign reset_flag = reset_flag_q;

endmodule

// File: tb/tb_puzzle_board.sv
// Self-checking bench for puzzle_board: directed scenarios plus randomized button traffic
// checked cycle by cycle against an array-based model of the puzzle rules.
module tb_puzzle_board;

  localparam int S = 2;
  localparam logic [4:0] B_RST = 5'b00001;
  localparam logic [4:0] B_UP  = 5'b00010;
  localparam logic [4:0] B_DN  = 5'b00100;
  localparam logic [4:0] B_LT  = 5'b01000;
  localparam logic [4:0] B_RT  = 5'b10000;
`ifdef LOCK_ON_WIN_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk_d = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_sw = 1'b0;
  logic [1:0]  board_sel = 2'd0;
  logic [4:0]  btns = 5'd0;
  logic [35:0] board;
  logic [3:0]  blank_pos;
  logic        active, win_flag, reset_flag;

  int compared = 0;
  int mismatched = 0;
  int activeCount = 0;
  int resetCount = 0;

  // Reference model state
  int         cells[9];
  bit         inPlay;
  logic [4:0] hist[$];
  logic       expActive, expRst, expWin;

  puzzle_board #(.SYNC_STAGES(S)) dut (
    .clk_d(clk_d), .rst_n(rst_n), .start_sw(start_sw), .board_sel(board_sel),
    .btn_up(btns[1]), .btn_down(btns[2]), .btn_left(btns[3]), .btn_right(btns[4]),
    .btn_reset(btns[0]), .board(board), .blank_pos(blank_pos), .active(active),
    .win_flag(win_flag), .reset_flag(reset_flag)
  );

  always #5 clk_d = ~clk_d;

  task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void loadPreset(input logic [1:0] sel);
    case (sel)
      2'd0: cells = '{1, 2, 3, 4, 5, 6, 7, 0, 8};
      2'd1: cells = '{1, 2, 3, 4, 0, 6, 7, 5, 8};
      2'd2: cells = '{0, 1, 3, 4, 2, 5, 7, 8, 6};
      default: cells = '{1, 3, 0, 4, 2, 5, 7, 8, 6};
    endcase
  endfunction

  function automatic bit isSolved();
    for (int i = 0; i < 8; i++) if (cells[i] != i + 1) return 1'b0;
    return cells[8] == 0;
  endfunction

  function automatic int blankIdx();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return i;
    return 15;
  endfunction

  function automatic logic [35:0] packCells();
    logic [35:0] v = '0;
    for (int i = 0; i < 9; i++) v[4*i +: 4] = 4'(cells[i]);
    return v;
  endfunction

  function automatic void modelReset();
    loadPreset(2'd0);
    inPlay = 1'b0;
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back(5'd0);
    expActive = 1'b0;
    expRst = 1'b0;
    expWin = 1'b0;
  endfunction

  // One clock edge of the game: a button event surfaces S+1 edges after it is first sampled.
  function automatic void modelStep(input bit start, input logic [1:0] sel, input logic [4:0] btn);
    logic [4:0] ev;
    int b, t, tmp;
    ev = hist[S-1] & ~hist[S];
    expWin = isSolved();
    expActive = 1'b0;
    expRst = 1'b0;
    if (!inPlay) begin
      loadPreset(sel);
      if (start) inPlay = 1'b1;
    end else if (!start) begin
      inPlay = 1'b0;
    end else if (ev[0]) begin
      loadPreset(sel);
      expRst = 1'b1;
    end else if (!(LOCK && isSolved())) begin
      b = blankIdx();
      t = -1;
      if (ev[1])      begin if (b / 3 > 0) t = b - 3; end
      else if (ev[2]) begin if (b / 3 < 2) t = b + 3; end
      else if (ev[3]) begin if (b % 3 > 0) t = b - 1; end
      else if (ev[4]) begin if (b % 3 < 2) t = b + 1; end
      if (t >= 0) begin
        tmp = cells[t];
        cells[t] = 0;
        cells[b] = tmp;
        expActive = 1'b1;
      end
    end
    hist.push_front(btn);
    void'(hist.pop_back());
  endfunction

  task automatic cycle();
    @(posedge clk_d);
    modelStep(start_sw, board_sel, btns);
    #1;
    activeCount += int'(active);
    resetCount += int'(reset_flag);
    checkOutput("board", board, packCells());
    checkOutput("blank_pos", {32'd0, blank_pos}, 36'(blankIdx()));
    checkOutput("active", {35'd0, active}, {35'd0, expActive});
    checkOutput("win_flag", {35'd0, win_flag}, {35'd0, expWin});
    checkOutput("reset_flag", {35'd0, reset_flag}, {35'd0, expRst});
  endtask

  task automatic applyStimulus(input bit start, input logic [1:0] sel, input logic [4:0] b, input int n);
    start_sw = start;
    board_sel = sel;
    btns = b;
    repeat (n) cycle();
  endtask

  task automatic press(input logic [1:0] sel, input logic [4:0] b);
    applyStimulus(1'b1, sel, b, 2);
    applyStimulus(1'b1, sel, 5'd0, 4);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_board"}, board, 36'h807654321);
    checkOutput({tag, "_blank"}, {32'd0, blank_pos}, 36'd7);
    checkOutput({tag, "_flags"}, {33'd0, active, win_flag, reset_flag}, 36'd0);
  endtask

  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    modelReset();
    @(posedge clk_d);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic startGame(input logic [1:0] sel);
    applyStimulus(1'b0, sel, 5'd0, 2);
    applyStimulus(1'b1, sel, 5'd0, 1);
    activeCount = 0;
    resetCount = 0;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk_d);
    #1;
    checkReset("reset");
    rst_n = 1'b1;

    // 1: preset 0, one move right solves it
    startGame(2'd0);
    press(2'd0, B_RT);
    checkOutput("t1_board", board, 36'h087654321);
    checkOutput("t1_blank", {32'd0, blank_pos}, 36'd8);
    checkOutput("t1_win", {35'd0, win_flag}, 36'd1);
    checkOutput("t1_pulses", 36'(activeCount), 36'd1);

    // 2: preset 3 solved in four moves
    startGame(2'd3);
    press(2'd3, B_LT);
    checkOutput("t2_blank_a", {32'd0, blank_pos}, 36'd1);
    press(2'd3, B_DN);
    checkOutput("t2_blank_b", {32'd0, blank_pos}, 36'd4);
    press(2'd3, B_RT);
    checkOutput("t2_blank_c", {32'd0, blank_pos}, 36'd5);
    press(2'd3, B_DN);
    checkOutput("t2_blank_d", {32'd0, blank_pos}, 36'd8);
    checkOutput("t2_win", {35'd0, win_flag}, 36'd1);
    checkOutput("t2_pulses", 36'(activeCount), 36'd4);

    // 3: blank in the corner, up and left are both illegal
    startGame(2'd2);
    press(2'd2, B_UP);
    press(2'd2, B_LT);
    checkOutput("t3_pulses", 36'(activeCount), 36'd0);
    checkOutput("t3_board", board, 36'h687524310);

    // 4: move then restart
    startGame(2'd1);
    press(2'd1, B_DN);
    press(2'd1, B_RST);
    checkOutput("t4_rflags", 36'(resetCount), 36'd1);
    checkOutput("t4_pulses", 36'(activeCount), 36'd1);
    checkOutput("t4_board", board, 36'h857604321);

    // 5: restart outranks moves, up outranks right
    activeCount = 0;
    resetCount = 0;
    press(2'd1, B_UP | B_RT | B_RST);
    checkOutput("t5_rflags", 36'(resetCount), 36'd1);
    checkOutput("t5_pulses_a", 36'(activeCount), 36'd0);
    press(2'd1, B_UP | B_RT);
    checkOutput("t5_blank", {32'd0, blank_pos}, 36'd1);
    checkOutput("t5_pulses_b", 36'(activeCount), 36'd1);

    // 6: moving after the win, then leaving play, then async reset mid-press
    startGame(2'd0);
    press(2'd0, B_RT);
    press(2'd0, B_UP);
`ifdef LOCK_ON_WIN_EN
    checkOutput("t6_blank", {32'd0, blank_pos}, 36'd8);
    checkOutput("t6_win", {35'd0, win_flag}, 36'd1);
`else
    checkOutput("t6_blank", {32'd0, blank_pos}, 36'd5);
    checkOutput("t6_win", {35'd0, win_flag}, 36'd0);
`endif
    applyStimulus(1'b0, 2'd2, 5'd0, 2);
    checkOutput("t6_reload", board, 36'h687524310);
    startGame(2'd3);
    applyStimulus(1'b1, 2'd3, B_LT, 2);
    asyncReset();
    applyStimulus(1'b0, 2'd0, 5'd0, 2);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      logic [4:0] b;
      int r;
      bit st;
      logic [1:0] sel;
      st = ($urandom_range(0, 24) != 0);
      sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0) b = 5'($urandom_range(0, 31));
      else if (r == 1) b = B_RST;
      else b = 5'(1 << $urandom_range(1, 4));
      applyStimulus(st, sel, b, $urandom_range(1, 3));
      applyStimulus(st, sel, 5'd0, $urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) asyncReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
